// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data SRAM between the CPU MEM stage (priority) and the host port.
// Define DMEM_ARB_PERF_EN to add saturating stall / forced-host-grant counters.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    // Handshakes: a requester asserts req with stable wen/addr/wdata and keeps it until
    // accepted; cpu accepted when req & ~cpu_stall, host when host_gnt (both same-cycle).
    // Read data returns exactly one cycle after acceptance as an rvalid pulse.
    input  logic              cpu_req_i,
    input  logic              cpu_wen_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_stall_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    input  logic              host_req_i,
    input  logic              host_wen_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic              mem_ren_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       cpu_stall_cycles_o,
    output logic [31:0]       host_force_cnt_o,
`endif
    output logic              dbg_state_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    typedef enum logic {
        CPU_PRI    = 1'b0,
        HOST_FORCE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_own_q, rd_own_d;
    logic             cpu_gnt;
    logic             host_gnt;
    logic [CNT_W-1:0] burst_inc;

    // State register
    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            state_q   <= CPU_PRI;
            burst_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            rd_pend_q <= rd_pend_d;
            rd_own_q  <= rd_own_d;
        end
    end

    assign burst_inc = burst_q + CNT_W'(1);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        rd_pend_d = mem_ren_o;
        rd_own_d  = host_gnt;
        case (state_q)
            CPU_PRI: begin
                if (!host_req_i) begin
                    burst_d = '0;
                end else if (cpu_gnt) begin
                    burst_d = burst_inc;
                    if (burst_inc == BURST_LIMIT) begin
                        state_d = HOST_FORCE;
                    end
                end else if (host_gnt) begin
                    burst_d = '0;
                end
            end
            HOST_FORCE: begin
                if (host_gnt || !host_req_i) begin
                    state_d = CPU_PRI;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = CPU_PRI;
                burst_d = '0;
            end
        endcase
    end

    // Output logic: grants, SRAM mux and read-return steering; reset blocks every grant
    always_comb begin
        host_gnt      = arst_n_i & host_req_i & (~cpu_req_i | (state_q == HOST_FORCE));
        cpu_gnt       = arst_n_i & cpu_req_i & ~host_gnt;
        cpu_stall_o   = cpu_req_i & ~cpu_gnt;
        host_gnt_o    = host_gnt;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_wen_o     = 1'b0;
        mem_ren_o     = 1'b0;
        if (host_gnt) begin
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
            mem_wen_o   = host_wen_i;
            mem_ren_o   = ~host_wen_i;
        end else if (cpu_gnt) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            mem_wen_o   = cpu_wen_i;
            mem_ren_o   = ~cpu_wen_i;
        end
        cpu_rvalid_o  = arst_n_i & rd_pend_q & ~rd_own_q;
        host_rvalid_o = arst_n_i & rd_pend_q & rd_own_q;
        cpu_rdata_o   = cpu_rvalid_o ? mem_rdata_i : '0;
        host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
        dbg_state_o   = state_q;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] force_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            stall_cycles_q <= '0;
            force_cnt_q    <= '0;
        end else begin
            if (cpu_stall_o && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (host_gnt && (state_q == HOST_FORCE) && (force_cnt_q != 32'hFFFF_FFFF)) begin
                force_cnt_q <= force_cnt_q + 32'd1;
            end
        end
    end

    assign cpu_stall_cycles_o = stall_cycles_q;
    assign host_force_cnt_o   = force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a one-cycle-latency SRAM model behind the port.
module tb_dmem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              arst_n;
    logic              cpu_req, cpu_wen, cpu_stall, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              host_req, host_wen, host_gnt, host_rvalid;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen, mem_ren;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              dbg_state;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       cpu_stall_cycles, host_force_cnt;
`endif

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .cpu_req_i(cpu_req), .cpu_wen_i(cpu_wen), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .host_req_i(host_req), .host_wen_i(host_wen), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata),
        .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_ren_o(mem_ren),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
`ifdef DMEM_ARB_PERF_EN
        .cpu_stall_cycles_o(cpu_stall_cycles), .host_force_cnt_o(host_force_cnt),
`endif
        .dbg_state_o(dbg_state)
    );

    // SRAM model with a bench-only preload port
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) sram[pl_addr] <= pl_data;
        else if (mem_wen) sram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 1'b0; host_wen = 1'b0; host_addr = '0; host_wdata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        tick();
        tick();
        preload(10'd5, 32'h0000_A5A5);
        preload(10'd1, 32'h1111_0001);
        preload(10'd2, 32'h2222_0002);
        preload(10'd8, 32'h0000_8888);
        cpu_req = 1'b1; host_req = 1'b1; cpu_addr = 10'd5;
        #1;
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_cpu_stall: got %0h want 1", cpu_stall); end
        total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL rst_host_gnt: got %0h want 0", host_gnt); end
        total++; if ({mem_ren, mem_wen} !== 2'b00) begin bad++; $display("FAIL rst_mem_en: got %0b want 00", {mem_ren, mem_wen}); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr: got %0h want 0", mem_addr); end
        total++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %0b want 00", {cpu_rvalid, host_rvalid}); end
        total++; if ({cpu_rdata, host_rdata} !== '0) begin bad++; $display("FAIL rst_rdata: got %0h/%0h want 0/0", cpu_rdata, host_rdata); end
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL rst_state: got %0h want 0", dbg_state); end
        cpu_req = 1'b0;
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall_idle: got %0h want 0", cpu_stall); end
        host_req = 1'b0;
    endtask

    task automatic test_cpu_only();
        tick();
        arst_n = 1'b1;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 10'd5;
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_stall: got %0h want 0", cpu_stall); end
        total++; if ({mem_ren, mem_wen} !== 2'b10) begin bad++; $display("FAIL cpu_mem_en: got %0b want 10", {mem_ren, mem_wen}); end
        total++; if (mem_addr !== 10'd5) begin bad++; $display("FAIL cpu_mem_addr: got %0h want 5", mem_addr); end
        tick();
        cpu_req = 1'b0;
        #1;
        total++; if (cpu_rvalid !== 1'b1) begin bad++; $display("FAIL cpu_rvalid: got %0h want 1", cpu_rvalid); end
        total++; if (cpu_rdata !== 32'h0000_A5A5) begin bad++; $display("FAIL cpu_rdata: got %0h want a5a5", cpu_rdata); end
        total++; if ({host_rvalid, host_rdata} !== '0) begin bad++; $display("FAIL cpu_host_quiet: got %0h/%0h want 0/0", host_rvalid, host_rdata); end
        total++; if ({mem_ren, mem_addr} !== '0) begin bad++; $display("FAIL idle_mem: got ren=%0h addr=%0h want 0/0", mem_ren, mem_addr); end
    endtask

    task automatic test_host_only();
        tick();
        host_req = 1'b1; host_wen = 1'b1; host_addr = 10'd3; host_wdata = 32'h0000_1234;
        #1;
        total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL host_wr_gnt: got %0h want 1", host_gnt); end
        total++; if ({mem_ren, mem_wen} !== 2'b01) begin bad++; $display("FAIL host_wr_en: got %0b want 01", {mem_ren, mem_wen}); end
        total++; if (mem_addr !== 10'd3) begin bad++; $display("FAIL host_wr_addr: got %0h want 3", mem_addr); end
        total++; if (mem_wdata !== 32'h0000_1234) begin bad++; $display("FAIL host_wr_data: got %0h want 1234", mem_wdata); end
        tick();
        host_wen = 1'b0;
        #1;
        total++; if ({cpu_rvalid, host_rvalid} !== 2'b00) begin bad++; $display("FAIL write_no_rvalid: got %0b want 00", {cpu_rvalid, host_rvalid}); end
        total++; if ({host_gnt, mem_ren} !== 2'b11) begin bad++; $display("FAIL host_rd_gnt: got %0b want 11", {host_gnt, mem_ren}); end
        tick();
        host_req = 1'b0;
        #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL host_rvalid: got %0h want 1", host_rvalid); end
        total++; if (host_rdata !== 32'h0000_1234) begin bad++; $display("FAIL host_rdata: got %0h want 1234", host_rdata); end
        total++; if ({cpu_rvalid, cpu_rdata} !== '0) begin bad++; $display("FAIL host_cpu_quiet: got %0h/%0h want 0/0", cpu_rvalid, cpu_rdata); end
    endtask

    task automatic test_contention();
        logic [9:0] exp_host;
        exp_host = 10'b10_0001_0000;   // host wins in cycles 4 and 9
        for (int c = 0; c < 10; c++) begin
            tick();
            cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 10'd7;
            host_req = 1'b1; host_wen = 1'b0; host_addr = 10'd8;
            #1;
            total++; if (cpu_stall !== exp_host[c]) begin bad++; $display("FAIL cont_stall[%0d]: got %0h want %0h", c, cpu_stall, exp_host[c]); end
            total++; if (host_gnt !== exp_host[c]) begin bad++; $display("FAIL cont_host_gnt[%0d]: got %0h want %0h", c, host_gnt, exp_host[c]); end
            if (c == 4) begin
                total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL cont_force_state: got %0h want 1", dbg_state); end
            end
            if (c == 5) begin
                total++; if ({cpu_rvalid, host_rvalid} !== 2'b01) begin bad++; $display("FAIL cont_owner: got %0b want 01", {cpu_rvalid, host_rvalid}); end
                total++; if (host_rdata !== 32'h0000_8888) begin bad++; $display("FAIL cont_host_rdata: got %0h want 8888", host_rdata); end
            end
        end
        tick();
        cpu_req = 1'b0; host_req = 1'b0;
        #1;
        total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL cont_last_rvalid: got %0h want 1", host_rvalid); end
`ifdef DMEM_ARB_PERF_EN
        total++; if (cpu_stall_cycles !== 32'd2) begin bad++; $display("FAIL perf_stall: got %0d want 2", cpu_stall_cycles); end
        total++; if (host_force_cnt !== 32'd2) begin bad++; $display("FAIL perf_force: got %0d want 2", host_force_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        tick();
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 10'd1;
        #1;
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL b2b_cpu_stall: got %0h want 0", cpu_stall); end
        tick();
        cpu_req = 1'b0;
        host_req = 1'b1; host_wen = 1'b0; host_addr = 10'd2;
        #1;
        total++; if ({cpu_rvalid, host_rvalid} !== 2'b10) begin bad++; $display("FAIL b2b_t1_valid: got %0b want 10", {cpu_rvalid, host_rvalid}); end
        total++; if (cpu_rdata !== 32'h1111_0001) begin bad++; $display("FAIL b2b_cpu_rdata: got %0h want 11110001", cpu_rdata); end
        total++; if (host_gnt !== 1'b1) begin bad++; $display("FAIL b2b_host_gnt: got %0h want 1", host_gnt); end
        tick();
        host_req = 1'b0;
        #1;
        total++; if ({cpu_rvalid, host_rvalid} !== 2'b01) begin bad++; $display("FAIL b2b_t2_valid: got %0b want 01", {cpu_rvalid, host_rvalid}); end
        total++; if (host_rdata !== 32'h2222_0002) begin bad++; $display("FAIL b2b_host_rdata: got %0h want 22220002", host_rdata); end
    endtask

    task automatic test_reset_mid_read();
        for (int c = 0; c < 3; c++) begin
            tick();
            cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 10'd7;
            host_req = 1'b1; host_wen = 1'b0; host_addr = 10'd8;
        end
        tick();
        cpu_addr = 10'd5;
        #1;
        total++; if ({cpu_stall, mem_ren} !== 2'b01) begin bad++; $display("FAIL rmr_grant: got %0b want 01", {cpu_stall, mem_ren}); end
        tick();
        arst_n = 1'b0;
        #1;
        total++; if ({cpu_rvalid, cpu_rdata} !== '0) begin bad++; $display("FAIL rmr_no_rvalid: got %0h/%0h want 0/0", cpu_rvalid, cpu_rdata); end
        total++; if ({cpu_stall, host_gnt} !== 2'b10) begin bad++; $display("FAIL rmr_no_gnt: got %0b want 10", {cpu_stall, host_gnt}); end
        total++; if ({mem_ren, mem_wen} !== 2'b00) begin bad++; $display("FAIL rmr_mem_en: got %0b want 00", {mem_ren, mem_wen}); end
        total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL rmr_force_before: got %0h want 1", dbg_state); end
        tick();
        arst_n = 1'b1;
        #1;
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL rmr_state_after: got %0h want 0", dbg_state); end
        total++; if ({cpu_stall, host_gnt} !== 2'b00) begin bad++; $display("FAIL rmr_cpu_priority: got %0b want 00", {cpu_stall, host_gnt}); end
        total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_rvalid_after: got %0h want 0", cpu_rvalid); end
        tick();
        cpu_req = 1'b0; host_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_only();
        test_host_only();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
